// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
// Sequential 4x4 unsigned multiplier controller. Operands are taken through a
// valid/ready handshake, multiplied by a radix-4 shift-add sequence that
// retires two multiplier bits per STEP cycle, and the 8-bit result is offered
// through a second valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair offered
//   in_ready   controller idle and able to accept operands
//   a, b       4-bit unsigned multiplicand / multiplier
//   out_valid  product holds a finished result
//   out_ready  consumer takes the result
//   product    8-bit unsigned a*b (zero while out_valid is low)
//   busy       controller is in the STEP state
//
// Optional feature
//   MULT_ZERO_SKIP_EN  terminate early once the remaining multiplier bits are
//                      all zero (b==0 goes straight from IDLE to DONE).
//                      Products are identical either way; only latency changes.

module mult_seq_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] product,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STEP = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] acc;
  logic [7:0] mcand;
  logic [3:0] mplier;
  logic [1:0] step_cnt;
  logic [7:0] partial;
  logic       accept;
  logic       last_step;

  // Operands are captured only from IDLE; anything offered while a multiply
  // is in flight is simply not seen.
  assign accept = (state == IDLE) && in_valid;

  // Partial product for the current radix-4 digit. The digit is at most 3,
  // so a shift plus one add covers every case without a real multiplier.
  always_comb begin
    partial = 8'd0;
    case (mplier[1:0])
      2'd0:    partial = 8'd0;
      2'd1:    partial = mcand;
      2'd2:    partial = mcand << 1;
      default: partial = (mcand << 1) + mcand;
    endcase
  end

  // The step in progress is the final one either when both digits have been
  // retired or, with zero skipping, when no set multiplier bits remain above
  // the digit being consumed now.
  always_comb begin
`ifdef MULT_ZERO_SKIP_EN
    last_step = (step_cnt == 2'd1) || (mplier[3:2] == 2'b00);
`else
    last_step = (step_cnt == 2'd1);
`endif
  end

  // State register. The async reset drops any operation in flight, so a
  // reset in STEP or DONE never delivers a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. DONE waits for the consumer, and returning to IDLE
  // costs one edge before the next operand pair can be taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
`ifdef MULT_ZERO_SKIP_EN
          state_next = (b == 4'd0) ? DONE : STEP;
`else
          state_next = STEP;
`endif
        end
      end
      STEP: begin
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath. Acceptance loads a fresh copy of the operands so later changes
  // on a/b cannot disturb the running multiply. Each STEP adds the current
  // digit's partial product and shifts both operands by one radix-4 digit.
  // The accumulator cannot overflow because 15*15 fits in 8 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= 8'd0;
      mcand    <= 8'd0;
      mplier   <= 4'd0;
      step_cnt <= 2'd0;
    end else if (accept) begin
      acc      <= 8'd0;
      mcand    <= {4'b0000, a};
      mplier   <= b;
      step_cnt <= 2'd0;
    end else if (state == STEP) begin
      acc      <= acc + partial;
      mcand    <= mcand << 2;
      mplier   <= mplier >> 2;
      step_cnt <= step_cnt + 2'd1;
    end
  end

  // Handshake outputs decode straight from the state so they follow the
  // async reset immediately. product is gated so it reads zero unless a
  // finished result is being offered.
  assign in_ready  = (state == IDLE);
  assign busy      = (state == STEP);
  assign out_valid = (state == DONE);
  assign product   = out_valid ? acc : 8'd0;

endmodule

// File: doc/mult_seq_ctrl.md
MULT_SEQ_CTRL -- requirements
Module: mult_seq_ctrl

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: the asynchronous, active-low reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: the operand pair is offered.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: the controller can accept operands.
REQ-005 The block SHALL have the ports a and b, input, 4 bits each: unsigned multiplicand and multiplier.
REQ-006 The block SHALL have the port out_valid, output, 1 bit: product holds a finished result.
REQ-007 The block SHALL have the port out_ready, input, 1 bit: the consumer takes the result.
REQ-008 The block SHALL have the port product, output, 8 bits: the unsigned product a*b.
REQ-009 The block SHALL have the port busy, output, 1 bit: the controller is high in the STEP state.

Function
REQ-010 The controller SHALL be a radix-4 shift-add sequencer that retires 2 multiplier bits per STEP cycle.
REQ-011 The FSM SHALL have the states IDLE, STEP and DONE, and SHALL use no other reachable states.
REQ-012 in_ready SHALL be 1 only in IDLE, so that operands are never accepted while an operation is in flight.
REQ-013 Acceptance SHALL occur on a rising edge with in_valid=1 and in_ready=1, which loads mcand={4'b0,a}, mplier=b, acc=0 and step_cnt=0, then moves to STEP.
REQ-014 Each STEP edge SHALL perform acc <= acc + mcand*mplier[1:0] (8-bit, no overflow possible), mcand <= mcand<<2 (zero-fill, MSBs discarded), mplier <= mplier>>2, and step_cnt <= step_cnt+1.
REQ-015 STEP SHALL go to DONE on the edge that completes step 2 (step_cnt==1 at that edge).
REQ-016 DONE SHALL drive out_valid=1 and product=acc.
REQ-017 product SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 DONE SHALL return to IDLE on an edge with out_ready=1, and out_valid SHALL drop after that edge.
REQ-019 The latency SHALL be: out_valid rises on the 2nd rising edge after the acceptance edge.
REQ-020 The accepted operands SHALL be used, and a/b changes after acceptance SHALL be ignored.
REQ-021 in_valid SHALL be ignored outside IDLE, with no queueing.
REQ-022 After a DONE->IDLE edge, a new operand pair SHALL be accepted no earlier than the next edge, giving a throughput of at most one result every 4 cycles.
REQ-023 product SHALL be 0 whenever out_valid=0.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force IDLE, acc=0, mcand=0, mplier=0, step_cnt=0, out_valid=0, busy=0, product=0 and in_ready=1.
REQ-025 Reset asserted mid-STEP or in DONE SHALL abort the operation with no result delivered.
REQ-026 After reset release, the first edge with in_valid=1 SHALL be accepted normally.

Configuration
REQ-027 The macro MULT_ZERO_SKIP_EN SHALL enable early termination.
REQ-028 With MULT_ZERO_SKIP_EN defined and b==0 at acceptance, the FSM SHALL go IDLE->DONE directly with acc=0, and out_valid SHALL be 1 after the acceptance edge.
REQ-029 With MULT_ZERO_SKIP_EN defined, a STEP edge where the remaining mplier>>2 is 0 SHALL go to DONE, so that b[3:2]==0 gives out_valid on the 1st edge after acceptance.
REQ-030 Without MULT_ZERO_SKIP_EN, every operation SHALL take exactly 2 STEP cycles regardless of b.
REQ-031 Products SHALL be identical with and without MULT_ZERO_SKIP_EN.

Verification
REQ-032 The bench SHALL cover: a=15, b=15, out_ready=1 -> product=225, with out_valid on the 2nd edge after acceptance and high for 1 cycle.
REQ-033 The bench SHALL cover: a=3, b=5, out_ready=0 for 5 cycles then 1 -> product=15, held stable all 5 cycles, and in_ready=0 throughout.
REQ-034 The bench SHALL cover: a=9, b=6 then new a=1, b=1 pulsed during STEP -> product=54, with the in-flight operands ignored.
REQ-035 The bench SHALL cover: rst_n=0 during the 1st STEP cycle of a=7, b=7 -> all outputs at reset values at once, and no out_valid until a new acceptance.
REQ-036 The bench SHALL cover, with MULT_ZERO_SKIP_EN: a=7, b=2 -> product=14 on the 1st edge; a=7, b=0 -> product=0 right after acceptance; without the macro, both take 2 edges.
REQ-037 The bench SHALL cover an exhaustive sweep of all 256 a/b pairs with out_ready=1 -> every product equals a*b.
